// File: rtl/cache_pkg.sv
// Shared types and width helpers for the write-back set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESPOND,
    FLUSH,
    FLUSH_DONE_S
  } state_t;

  function automatic int addr_w(input int tag_w, input int index_w, input int offset_w);
    return tag_w + index_w + offset_w;
  endfunction

  function automatic int ram_data_w(input int cpu_data_w, input int offset_w);
    return cpu_data_w << offset_w;
  endfunction

  function automatic int be_w(input int cpu_data_w);
    return cpu_data_w / 8;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU bookkeeping: one age per way per set, victim choice and update.
module cache_lru #(
  parameter int INDEX_W = 4,
  parameter int WAYS    = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [INDEX_W-1:0]       set_idx,
  input  logic [WAYS-1:0]          valid_vec,
  input  logic                     touch,
  input  logic [$clog2(WAYS)-1:0]  touch_way,
  output logic [$clog2(WAYS)-1:0]  victim
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = $clog2(WAYS);

  logic [WAY_W-1:0] age [SETS][WAYS];
  logic             found;

  // Victim: lowest-index invalid way, otherwise the oldest way of the set.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_vec[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[set_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  // Ages younger than the touched way grow by one; the touched way becomes youngest.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[set_idx][w] < age[set_idx][touch_way])
          age[set_idx][w] <= age[set_idx][w] + 1'b1;
      end
      age[set_idx][touch_way] <= '0;
    end
  end

endmodule

// File: rtl/cache_memory_wb.sv
// N-way set-associative write-back, write-allocate cache between CPU and MI.
module cache_memory_wb
  import cache_pkg::*;
#(
  parameter int  TAG_W      = 8,
  parameter int  INDEX_W    = 4,
  parameter int  OFFSET_W   = 2,
  parameter int  CPU_DATA_W = 32,
  parameter int  WAYS       = 4,
  localparam int ADDR_W     = addr_w(TAG_W, INDEX_W, OFFSET_W),
  localparam int RAM_DATA_W = ram_data_w(CPU_DATA_W, OFFSET_W),
  localparam int BE_W       = be_w(CPU_DATA_W)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        CPU_ADDR,
  input  logic                     SIG_CPU_RD,
  input  logic                     SIG_CPU_WR,
  input  logic [CPU_DATA_W-1:0]    CPU_OUT_DATA,
  input  logic [BE_W-1:0]          CPU_B_VAL,
  input  logic                     SIG_FLUSH,
  output logic                     ACK,
  output logic [CPU_DATA_W-1:0]    CPU_IN_DATA,
  output logic                     FLUSH_DONE,
  output logic                     SIG_RAM_RD,
  output logic                     SIG_RAM_WR,
  output logic [TAG_W+INDEX_W-1:0] RAM_ADDR,
  output logic [RAM_DATA_W-1:0]    MI_IN_DATA,
  input  logic [RAM_DATA_W-1:0]    MI_OUT_DATA,
  input  logic                     MI_SIG_RAM_ACK
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam int ENT_W = INDEX_W + WAY_W;
  localparam logic [ENT_W-1:0] LAST_ENT = '1;

  state_t                  state;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_W-1:0]      req_idx;
  logic [OFFSET_W-1:0]     req_off;
  logic                    req_wr;
  logic [CPU_DATA_W-1:0]   req_data;
  logic [BE_W-1:0]         req_be;
  logic [WAY_W-1:0]        vict_way;
  logic [ENT_W-1:0]        flush_cnt;

  logic [WAYS-1:0]         valid_q  [SETS];
  logic [WAYS-1:0]         dirty_q  [SETS];
  logic [TAG_W-1:0]        tag_mem  [SETS][WAYS];
  logic [RAM_DATA_W-1:0]   data_mem [SETS][WAYS];

  logic                    hit;
  logic [WAY_W-1:0]        hit_way;
  logic [RAM_DATA_W-1:0]   hit_line;
  logic [CPU_DATA_W-1:0]   hit_word;
  logic [CPU_DATA_W-1:0]   merged_word;
  logic [WAY_W-1:0]        lru_victim;
  logic [INDEX_W-1:0]      fl_set;
  logic [WAY_W-1:0]        fl_way;

  function automatic logic [CPU_DATA_W-1:0] merge_bytes(input logic [CPU_DATA_W-1:0] old_w,
                                                       input logic [CPU_DATA_W-1:0] new_w,
                                                       input logic [BE_W-1:0]       be);
    merge_bytes = old_w;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
  endfunction

  assign fl_set      = flush_cnt[ENT_W-1:WAY_W];
  assign fl_way      = flush_cnt[WAY_W-1:0];
  assign hit_line    = data_mem[req_idx][hit_way];
  assign hit_word    = hit_line[int'(req_off)*CPU_DATA_W +: CPU_DATA_W];
  assign merged_word = merge_bytes(hit_word, req_data, req_be);

  // Tag compare across all valid ways of the requested set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  cache_lru #(
    .INDEX_W (INDEX_W),
    .WAYS    (WAYS)
  ) u_lru (
    .CLK       (CLK),
    .RESET     (RESET),
    .set_idx   (req_idx),
    .valid_vec (valid_q[req_idx]),
    .touch     ((state == LOOKUP) && hit),
    .touch_way (hit_way),
    .victim    (lru_victim)
  );

  // Request capture and line storage; the arrays themselves are never cleared.
  always_ff @(posedge CLK) begin
    if (state == IDLE) begin
      req_tag  <= CPU_ADDR[ADDR_W-1 -: TAG_W];
      req_idx  <= CPU_ADDR[OFFSET_W +: INDEX_W];
      req_off  <= CPU_ADDR[OFFSET_W-1:0];
      req_wr   <= SIG_CPU_WR;
      req_data <= CPU_OUT_DATA;
      req_be   <= CPU_B_VAL;
    end
    if ((state == LOOKUP) && !hit)
      vict_way <= lru_victim;
    if (!RESET && (state == LOOKUP) && hit && req_wr)
      data_mem[req_idx][hit_way][int'(req_off)*CPU_DATA_W +: CPU_DATA_W] <= merged_word;
    if (!RESET && (state == REFILL) && MI_SIG_RAM_ACK) begin
      data_mem[req_idx][vict_way] <= MI_OUT_DATA;
      tag_mem[req_idx][vict_way]  <= req_tag;
    end
  end

  // Control FSM with registered CPU and MI outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      ACK         <= 1'b0;
      CPU_IN_DATA <= '0;
      FLUSH_DONE  <= 1'b0;
      SIG_RAM_RD  <= 1'b0;
      SIG_RAM_WR  <= 1'b0;
      RAM_ADDR    <= '0;
      MI_IN_DATA  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (SIG_FLUSH) begin
            flush_cnt <= '0;
            state     <= FLUSH;
          end else if (SIG_CPU_RD ^ SIG_CPU_WR) begin
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_wr) dirty_q[req_idx][hit_way] <= 1'b1;
            ACK         <= 1'b1;
            CPU_IN_DATA <= req_wr ? '0 : hit_word;
            state       <= RESPOND;
          end else if (valid_q[req_idx][lru_victim] && dirty_q[req_idx][lru_victim]) begin
            SIG_RAM_WR <= 1'b1;
            RAM_ADDR   <= {tag_mem[req_idx][lru_victim], req_idx};
            MI_IN_DATA <= data_mem[req_idx][lru_victim];
            state      <= WRITEBACK;
          end else begin
            SIG_RAM_RD <= 1'b1;
            RAM_ADDR   <= {req_tag, req_idx};
            state      <= REFILL;
          end
        end
        WRITEBACK: begin
          if (MI_SIG_RAM_ACK) begin
            SIG_RAM_WR <= 1'b0;
            SIG_RAM_RD <= 1'b1;
            RAM_ADDR   <= {req_tag, req_idx};
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (MI_SIG_RAM_ACK) begin
            SIG_RAM_RD                  <= 1'b0;
            valid_q[req_idx][vict_way]  <= 1'b1;
            dirty_q[req_idx][vict_way]  <= 1'b0;
            state                       <= LOOKUP;
          end
        end
        RESPOND: begin
          ACK         <= 1'b0;
          CPU_IN_DATA <= '0;
          state       <= IDLE;
        end
        FLUSH: begin
          if (SIG_RAM_WR) begin
            if (MI_SIG_RAM_ACK) begin
              SIG_RAM_WR              <= 1'b0;
              dirty_q[fl_set][fl_way] <= 1'b0;
              if (flush_cnt == LAST_ENT) begin
                FLUSH_DONE <= 1'b1;
                state      <= FLUSH_DONE_S;
              end else begin
                flush_cnt <= flush_cnt + 1'b1;
              end
            end
          end else if (valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way]) begin
            SIG_RAM_WR <= 1'b1;
            RAM_ADDR   <= {tag_mem[fl_set][fl_way], fl_set};
            MI_IN_DATA <= data_mem[fl_set][fl_way];
          end else if (flush_cnt == LAST_ENT) begin
            FLUSH_DONE <= 1'b1;
            state      <= FLUSH_DONE_S;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        FLUSH_DONE_S: begin
          FLUSH_DONE <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_memory_wb.sv
// Self-checking bench for cache_memory_wb: directed scenarios plus random traffic
// checked against a recency-ordered set model and a flat reference memory.
module tb_cache_memory_wb;

  logic         CLK;
  logic         RESET;
  logic [13:0]  CPU_ADDR;
  logic         SIG_CPU_RD;
  logic         SIG_CPU_WR;
  logic [31:0]  CPU_OUT_DATA;
  logic [3:0]   CPU_B_VAL;
  logic         SIG_FLUSH;
  logic         ACK;
  logic [31:0]  CPU_IN_DATA;
  logic         FLUSH_DONE;
  logic         SIG_RAM_RD;
  logic         SIG_RAM_WR;
  logic [11:0]  RAM_ADDR;
  logic [127:0] MI_IN_DATA;
  logic [127:0] MI_OUT_DATA;
  logic         MI_SIG_RAM_ACK;

  cache_memory_wb dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CPU_ADDR       (CPU_ADDR),
    .SIG_CPU_RD     (SIG_CPU_RD),
    .SIG_CPU_WR     (SIG_CPU_WR),
    .CPU_OUT_DATA   (CPU_OUT_DATA),
    .CPU_B_VAL      (CPU_B_VAL),
    .SIG_FLUSH      (SIG_FLUSH),
    .ACK            (ACK),
    .CPU_IN_DATA    (CPU_IN_DATA),
    .FLUSH_DONE     (FLUSH_DONE),
    .SIG_RAM_RD     (SIG_RAM_RD),
    .SIG_RAM_WR     (SIG_RAM_WR),
    .RAM_ADDR       (RAM_ADDR),
    .MI_IN_DATA     (MI_IN_DATA),
    .MI_OUT_DATA    (MI_OUT_DATA),
    .MI_SIG_RAM_ACK (MI_SIG_RAM_ACK)
  );

  typedef struct {
    logic [7:0] tag;
    bit         dirty;
  } mline_t;

  logic [127:0] mem     [4096];
  logic [127:0] ref_mem [4096];
  mline_t       sq      [16][$];
  logic [12:0]  act_log [$];
  logic [12:0]  exp_log [$];
  bit           mi_hold;
  int           mi_wait;
  int           n_cmp;
  int           n_err;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory-interface responder with a random 0..2 cycle wait per request.
  initial begin
    MI_SIG_RAM_ACK = 1'b0;
    MI_OUT_DATA    = '0;
    forever begin
      @(negedge CLK);
      if (MI_SIG_RAM_ACK) begin
        MI_SIG_RAM_ACK = 1'b0;
      end else if ((SIG_RAM_RD || SIG_RAM_WR) && !mi_hold && !RESET) begin
        if (mi_wait > 0) begin
          mi_wait--;
        end else begin
          if (SIG_RAM_WR) begin
            mem[RAM_ADDR] = MI_IN_DATA;
            act_log.push_back({1'b1, RAM_ADDR});
          end else begin
            MI_OUT_DATA = mem[RAM_ADDR];
            act_log.push_back({1'b0, RAM_ADDR});
          end
          MI_SIG_RAM_ACK = 1'b1;
          mi_wait = $urandom_range(0, 2);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, "_mi_count"}, 128'(act_log.size()), 128'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < act_log.size(); i++)
      check({tag, "_mi_op"}, 128'(act_log[i]), 128'(exp_log[i]));
  endtask

  // Reference: per-set list of resident tags, most recently used first.
  task automatic model_access(input bit wr, input logic [13:0] addr, input logic [31:0] d,
                              input logic [3:0] be, output bit hit, output logic [31:0] exp);
    logic [7:0]  tg;
    logic [3:0]  ix;
    logic [1:0]  of;
    logic [11:0] la;
    int          pos;
    mline_t      e;
    mline_t      v;
    tg  = addr[13:6];
    ix  = addr[5:2];
    of  = addr[1:0];
    la  = addr[13:2];
    pos = -1;
    for (int i = 0; i < sq[ix].size(); i++)
      if (sq[ix][i].tag == tg) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      e   = sq[ix][pos];
      sq[ix].delete(pos);
    end else begin
      hit = 1'b0;
      if (sq[ix].size() == 4) begin
        v = sq[ix].pop_back();
        if (v.dirty) exp_log.push_back({1'b1, v.tag, ix});
      end
      exp_log.push_back({1'b0, tg, ix});
      e.tag   = tg;
      e.dirty = 1'b0;
    end
    if (wr) begin
      e.dirty = 1'b1;
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[la][int'(of)*32 + 8*b +: 8] = d[8*b +: 8];
    end
    sq[ix].push_front(e);
    exp = ref_mem[la][int'(of)*32 +: 32];
  endtask

  task automatic cpu_op(input bit wr, input logic [13:0] addr, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rdata, output int cyc);
    @(negedge CLK);
    CPU_ADDR     = addr;
    CPU_OUT_DATA = d;
    CPU_B_VAL    = be;
    SIG_CPU_RD   = !wr;
    SIG_CPU_WR   = wr;
    @(posedge CLK);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!ACK && cyc < 100);
    rdata      = CPU_IN_DATA;
    check("ack_seen", 128'(ACK), 128'(1));
    SIG_CPU_RD = 1'b0;
    SIG_CPU_WR = 1'b0;
    @(negedge CLK);
    check("ack_pulse", 128'(ACK), 128'(0));
  endtask

  task automatic do_access(input bit wr, input logic [13:0] addr, input logic [31:0] d,
                           input logic [3:0] be, input string tag, output logic [31:0] rd);
    bit          hit;
    logic [31:0] exp;
    int          cyc;
    act_log.delete();
    exp_log.delete();
    model_access(wr, addr, d, be, hit, exp);
    cpu_op(wr, addr, d, be, rd, cyc);
    check({tag, "_data"}, 128'(rd), 128'(wr ? 32'h0 : exp));
    if (hit) check({tag, "_hit_latency"}, 128'(cyc), 128'(2));
    check_log(tag);
  endtask

  task automatic do_flush(input string tag);
    int     cyc;
    int     nbad;
    mline_t e;
    act_log.delete();
    exp_log.delete();
    for (int s = 0; s < 16; s++)
      for (int i = 0; i < sq[s].size(); i++)
        if (sq[s][i].dirty) begin
          exp_log.push_back({1'b1, sq[s][i].tag, 4'(s)});
          e       = sq[s][i];
          e.dirty = 1'b0;
          sq[s][i] = e;
        end
    @(negedge CLK);
    SIG_FLUSH = 1'b1;
    @(posedge CLK);
    cyc = 0;
    do begin
      @(negedge CLK);
      SIG_FLUSH = 1'b0;
      cyc++;
    end while (!FLUSH_DONE && cyc < 400);
    check({tag, "_done"}, 128'(FLUSH_DONE), 128'(1));
    if (exp_log.size() == 0) check({tag, "_latency"}, 128'(cyc), 128'(65));
    act_log.sort();
    exp_log.sort();
    check_log(tag);
    @(negedge CLK);
    check({tag, "_pulse"}, 128'(FLUSH_DONE), 128'(0));
    nbad = 0;
    for (int a = 0; a < 4096; a++)
      if (mem[a] !== ref_mem[a]) nbad++;
    check({tag, "_mem_lines"}, 128'(nbad), 128'(0));
  endtask

  initial begin
    logic [31:0] rd;
    logic [13:0] a;
    int          cyc;
    n_cmp        = 0;
    n_err        = 0;
    mi_hold      = 1'b0;
    mi_wait      = 0;
    RESET        = 1'b1;
    CPU_ADDR     = '0;
    SIG_CPU_RD   = 1'b0;
    SIG_CPU_WR   = 1'b0;
    CPU_OUT_DATA = '0;
    CPU_B_VAL    = '0;
    SIG_FLUSH    = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[12'h048] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ack", 128'(ACK), 128'(0));
    check("rst_ram_rd", 128'(SIG_RAM_RD), 128'(0));
    check("rst_ram_wr", 128'(SIG_RAM_WR), 128'(0));
    check("rst_flush_done", 128'(FLUSH_DONE), 128'(0));
    check("rst_ram_addr", 128'(RAM_ADDR), 128'(0));
    RESET = 1'b0;

    // Cold miss, then hit on the same word
    do_access(1'b0, 14'h0123, 32'h0, 4'h0, "t1", rd);
    check("t1_word", 128'(rd), 128'(32'hDDDDDDDD));
    check("t1_refill_addr", 128'(act_log[0]), 128'({1'b0, 12'h048}));
    do_access(1'b0, 14'h0123, 32'h0, 4'h0, "t2", rd);
    check("t2_no_mi", 128'(act_log.size()), 128'(0));

    // Partial write hit and readback
    do_access(1'b1, 14'h0122, 32'h11223344, 4'b0101, "t3w", rd);
    do_access(1'b0, 14'h0122, 32'h0, 4'h0, "t3r", rd);
    check("t3_merged", 128'(rd), 128'(32'hCC22CC44));

    // Fill set 8, then evict the dirty LRU line
    do_access(1'b0, 14'h0160, 32'h0, 4'h0, "t4a", rd);
    do_access(1'b0, 14'h01A1, 32'h0, 4'h0, "t4b", rd);
    do_access(1'b0, 14'h01E2, 32'h0, 4'h0, "t4c", rd);
    do_access(1'b0, 14'h0223, 32'h0, 4'h0, "t4d", rd);
    check("t4_wb_op", 128'(act_log[0]), 128'({1'b1, 12'h048}));
    check("t4_rd_op", 128'(act_log[1]), 128'({1'b0, 12'h088}));
    check("t4_wb_word2", 128'(mem[12'h048][95:64]), 128'(32'hCC22CC44));

    // Flush with one dirty line, then a clean flush
    do_access(1'b1, 14'h0220, 32'hA5A55A5A, 4'hF, "t5w", rd);
    do_flush("t5a");
    check("t5_one_write", 128'(act_log.size()), 128'(1));
    do_flush("t5b");

    // Simultaneous RD and WR is ignored
    act_log.delete();
    @(negedge CLK);
    CPU_ADDR   = 14'h0123;
    SIG_CPU_RD = 1'b1;
    SIG_CPU_WR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("rdwr_no_ack", 128'(ACK), 128'(0));
    end
    SIG_CPU_RD = 1'b0;
    SIG_CPU_WR = 1'b0;
    check("rdwr_no_mi", 128'(act_log.size()), 128'(0));

    // Random traffic in two sets with six competing tags
    for (int n = 0; n < 160; n++) begin
      a = {8'($urandom_range(0, 5)), 4'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      do_access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rnd", rd);
      if (n % 50 == 49) do_flush("rnd_flush");
    end
    do_flush("pre_rst_flush");

    // Reset while waiting for a refill
    mi_hold = 1'b1;
    @(negedge CLK);
    CPU_ADDR   = {8'h30, 4'h3, 2'h0};
    SIG_CPU_RD = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!SIG_RAM_RD && cyc < 20);
    check("t6_refill_seen", 128'(SIG_RAM_RD), 128'(1));
    RESET      = 1'b1;
    SIG_CPU_RD = 1'b0;
    @(negedge CLK);
    check("t6_rst_ram_rd", 128'(SIG_RAM_RD), 128'(0));
    check("t6_rst_ack", 128'(ACK), 128'(0));
    RESET   = 1'b0;
    mi_hold = 1'b0;
    for (int s = 0; s < 16; s++) sq[s].delete();
    do_access(1'b0, 14'h0123, 32'h0, 4'h0, "t6", rd);
    check("t6_miss_after_rst", 128'(act_log.size()), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_memory_wb.md
Name: cache_memory_wb

Overview:
- N-way set-associative, write-back, write-allocate data cache between the CPU and the memory interface (MI).
- Generalises the direct CPU/MI cache: it adds parametrised way count, per-line dirty bits, true-LRU replacement, victim write-back and a full-cache flush command.
- One cache line equals one MI word. The CPU accesses one CPU word per request, with per-byte write enables.

Parameters:
TAG_W, 8, address tag bits
INDEX_W, 4, set index bits (2**INDEX_W sets)
OFFSET_W, 2, CPU-word offset bits within a line (2**OFFSET_W words per line)
CPU_DATA_W, 32, CPU word width (multiple of 8)
WAYS, 4, associativity (power of 2, >=2)
Derived, not overridable: ADDR_W=TAG_W+INDEX_W+OFFSET_W; RAM_DATA_W=CPU_DATA_W<<OFFSET_W; BE_W=CPU_DATA_W/8

Ports:
CLK  in  1  clock, all state changes on rising edge
RESET  in  1  synchronous, active-high
CPU_ADDR  in  ADDR_W  {tag,index,offset}, CPU-word address
SIG_CPU_RD  in  1  read request
SIG_CPU_WR  in  1  write request
CPU_OUT_DATA  in  CPU_DATA_W  write data
CPU_B_VAL  in  BE_W  byte enables for writes
SIG_FLUSH  in  1  write back all dirty lines
ACK  out  1  one-cycle completion pulse for a RD/WR
CPU_IN_DATA  out  CPU_DATA_W  read data, valid while ACK=1
FLUSH_DONE  out  1  one-cycle flush completion pulse
SIG_RAM_RD  out  1  MI line read request
SIG_RAM_WR  out  1  MI line write request
RAM_ADDR  out  TAG_W+INDEX_W  MI line address {tag,index}
MI_IN_DATA  out  RAM_DATA_W  line written to MI
MI_OUT_DATA  in  RAM_DATA_W  line returned by MI
MI_SIG_RAM_ACK  in  1  MI completion; data valid on that cycle for reads

Behaviour:

Reset and request acceptance
- Reset (synchronous): state=IDLE; all valid and dirty bits=0; LRU age of way w in every set=w; all outputs 0. The data array is not cleared.
- Reset mid-operation aborts immediately: after the reset edge SIG_RAM_RD/WR=0, no ACK, and the partial refill is discarded.
- IDLE, SIG_FLUSH=1: latch, go to FLUSH. Flush has priority over a simultaneous CPU request.
- IDLE, exactly one of RD/WR=1: latch address, data and byte enables; go to LOOKUP.
- IDLE, RD=WR=1: ignored, stay IDLE.
- The CPU holds the request until ACK and drops it in the cycle after ACK.

LOOKUP (one cycle): compare the tag against all valid ways of the set.
- Hit, read: capture the selected word.
- Hit, write: merge enabled bytes into the word and set dirty.
- Any hit: update LRU, then go to RESPOND.
- Miss: victim = lowest-index invalid way; otherwise the way with age WAYS-1.
  - victim valid and dirty: go to WRITEBACK.
  - otherwise: go to REFILL.

WRITEBACK and REFILL
- WRITEBACK: SIG_RAM_WR=1, RAM_ADDR={victim tag,index}, MI_IN_DATA=victim line, all held stable until MI_SIG_RAM_ACK. On ack, go to REFILL.
- REFILL: SIG_RAM_RD=1, RAM_ADDR={req tag,index}. On ack:
  - write MI_OUT_DATA into the victim way;
  - valid=1, dirty=0, tag updated;
  - go to LOOKUP, which is then a guaranteed hit.
- The MI request drops in the cycle after ack.

RESPOND: ACK=1 for one cycle; CPU_IN_DATA = selected word for reads, 0 for writes; go to IDLE.

Latency
- Hit: ACK is high 2 cycles after the accepting edge.
- Miss: 2 + refill wait + 1, plus write-back wait if the victim is dirty.

LRU
- On access to way w, every way with age < age[w] increments and age[w]=0.
- Ages in a set always stay a permutation of 0..WAYS-1.

FLUSH
- A counter walks the entries {set,way} from 0 to 2**INDEX_W*WAYS-1, one entry per cycle.
- Valid and dirty entry: write back, then clear dirty. Valid stays 1 and LRU is unchanged.
- After the last entry: FLUSH_DONE=1 for one cycle, then IDLE.
- With no dirty lines, FLUSH_DONE is high in cycle 2**INDEX_W*WAYS+1 after the accepting edge.

Width rules
- Word k of a line is bits [k*CPU_DATA_W +: CPU_DATA_W].
- Byte b of a word is bits [8b +: 8].

Decomposition:
- Package cache_pkg: state enum (IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND, FLUSH, FLUSH_DONE_S) and derived-width functions.
- Sub-module cache_lru: per-set age array, victim selection and update.

Test Plan:
1. After reset, RD 0x0123 (tag 0x04, set 8, offset 3) -> SIG_RAM_RD with RAM_ADDR=0x048; MI returns 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> ACK with CPU_IN_DATA=0xDDDDDDDD; SIG_RAM_WR never asserted.
2. Repeat RD 0x0123 -> ACK 2 cycles after the accepting edge; no MI activity.
3. WR 0x0122, data 0x11223344, CPU_B_VAL=0b0101 -> hit; a later RD 0x0122 returns 0xCC22CC44.
4. RD tags 0x05/0x06/0x07 in set 8, then RD tag 0x08 set 8 -> SIG_RAM_WR RAM_ADDR=0x048 with word2 of MI_IN_DATA=0xCC22CC44, then SIG_RAM_RD RAM_ADDR=0x088.
5. SIG_FLUSH with one dirty line -> exactly one SIG_RAM_WR, then a FLUSH_DONE pulse. A second flush -> no MI traffic, FLUSH_DONE at cycle 65.
6. RESET asserted while waiting in REFILL -> after the edge SIG_RAM_RD=0, ACK=0; a previously cached address now misses.
